// File: rtl/aes_pkg.sv
// AES constants for the key expansion: S-box table, xtime, key/round sizes and FSM states.
package aes_pkg;

   localparam logic [3:0] NK_128 = 4'd4;
   localparam logic [3:0] NK_192 = 4'd6;
   localparam logic [3:0] NK_256 = 4'd8;
   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef enum logic [1:0] {StIdle, StExpand, StDone} ke_state_e;

   // Entry 0 is the leftmost byte of the literal below.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
module aes_sbox_word
   import aes_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   always_comb begin
      word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]), sbox(word_i[15:8]), sbox(word_i[7:0])};
   end

endmodule

// File: rtl/aes_key_expand.sv
// AES key expansion, one word per cycle, into a 16x128 round-key file.
// Define AES_KEY_ZEROIZE_EN to add iZeroize and clear the key file on zeroize/reset.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic        iClk,
   input  logic        iRst,
`ifdef AES_KEY_ZEROIZE_EN
   input  logic        iZeroize,
`endif
   input  logic        iKey_load,
   input  logic [3:0]  iKey_size,
   input  logic [31:0] iKey_1,
   input  logic [31:0] iKey_2,
   input  logic [31:0] iKey_3,
   input  logic [31:0] iKey_4,
   input  logic [31:0] iKey_5,
   input  logic [31:0] iKey_6,
   input  logic [31:0] iKey_7,
   input  logic [31:0] iKey_8,
   input  logic [3:0]  iRAM_addr,
   output logic [31:0] oRAM_data_1,
   output logic [31:0] oRAM_data_2,
   output logic [31:0] oRAM_data_3,
   output logic [31:0] oRAM_data_4,
   output logic        oBusy,
   output logic        oKey_ready,
   output logic        oParam_load,
   output logic [3:0]  oRound,
   output logic [3:0]  oSize
);

   ke_state_e   state_q, state_d;
   logic [5:0]  i_q, i_d;
   logic [2:0]  mod_q, mod_d;
   logic [7:0]  rcon_q, rcon_d;
   logic [3:0]  nk_q, nk_d, nr_q, nr_d;
   logic        busy_q, busy_d, ready_q, ready_d, param_q, param_d;
   logic [3:0]  round_q, round_d, size_q, size_d;
   logic [31:0] win_q [8];
   logic [31:0] win_d [8];
   logic [3:0][31:0] kf_q [16];
   logic [3:0][31:0] kf_d [16];

   logic        clr;
   logic [31:0] key_w [8];
   logic [3:0]  nk_sel, nr_sel;
   logic [2:0]  old_idx;
   logic [31:0] prev_w, sub_in, sub_out, t_w, new_w;

`ifdef AES_KEY_ZEROIZE_EN
   assign clr = iRst | iZeroize;
`else
   assign clr = iRst;
`endif

   assign key_w = '{iKey_1, iKey_2, iKey_3, iKey_4, iKey_5, iKey_6, iKey_7, iKey_8};

   always_comb begin
      unique case (iKey_size)
         NK_192:  begin nk_sel = NK_192; nr_sel = NR_192; end
         NK_256:  begin nk_sel = NK_256; nr_sel = NR_256; end
         default: begin nk_sel = NK_128; nr_sel = NR_128; end
      endcase
   end

   // win_q[0] is w[i-1]; win_q[Nk-1] is w[i-Nk].
   assign old_idx = nk_q[2:0] - 3'd1;
   assign prev_w  = win_q[0];
   assign sub_in  = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   aes_sbox_word u_sbox (
      .word_i (sub_in),
      .word_o (sub_out)
   );

   always_comb begin
      if (mod_q == 3'd0)                          t_w = sub_out ^ {rcon_q, 24'h0};
      else if (nk_q == NK_256 && mod_q == 3'd4)   t_w = sub_out;
      else                                        t_w = prev_w;
      new_w = win_q[old_idx] ^ t_w;
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      mod_d   = mod_q;
      rcon_d  = rcon_q;
      nk_d    = nk_q;
      nr_d    = nr_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      param_d = 1'b0;
      round_d = round_q;
      size_d  = size_q;
      win_d   = win_q;
      kf_d    = kf_q;
      if (iKey_load) begin
         nk_d    = nk_sel;
         nr_d    = nr_sel;
         i_d     = {2'b00, nk_sel};
         mod_d   = 3'd0;
         rcon_d  = 8'h01;
         state_d = StExpand;
         busy_d  = 1'b1;
         ready_d = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (4'(k) < nk_sel) begin
               win_d[3'(k)]             = key_w[3'(nk_sel - 4'd1 - 4'(k))];
               kf_d[4'(k >> 2)][2'(k)]  = key_w[3'(k)];
            end
         end
      end else if (state_q == StExpand) begin
         kf_d[i_q[5:2]][i_q[1:0]] = new_w;
         win_d[0] = new_w;
         for (int k = 1; k < 8; k++) begin
            win_d[3'(k)] = win_q[3'(k - 1)];
         end
         if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
         mod_d = (mod_q == old_idx) ? 3'd0 : mod_q + 3'd1;
         i_d   = i_q + 6'd1;
         if (i_q == {nr_q, 2'b11}) begin
            state_d = StDone;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            param_d = 1'b1;
            round_d = nr_q;
            size_d  = nk_q;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (clr) begin
         state_q <= StIdle;
         i_q     <= '0;
         mod_q   <= '0;
         rcon_q  <= 8'h01;
         nk_q    <= NK_128;
         nr_q    <= NR_128;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         param_q <= 1'b0;
         round_q <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         mod_q   <= mod_d;
         rcon_q  <= rcon_d;
         nk_q    <= nk_d;
         nr_q    <= nr_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         param_q <= param_d;
         round_q <= round_d;
         size_q  <= size_d;
      end
   end

`ifdef AES_KEY_ZEROIZE_EN
   always_ff @(posedge iClk) begin
      if (clr) begin
         kf_q  <= '{default: '0};
         win_q <= '{default: '0};
      end else begin
         kf_q  <= kf_d;
         win_q <= win_d;
      end
   end
`else
   // No reset so the key file can map onto RAM.
   always_ff @(posedge iClk) begin
      kf_q  <= kf_d;
      win_q <= win_d;
   end
`endif

   assign oRAM_data_1 = kf_q[iRAM_addr][0];
   assign oRAM_data_2 = kf_q[iRAM_addr][1];
   assign oRAM_data_3 = kf_q[iRAM_addr][2];
   assign oRAM_data_4 = kf_q[iRAM_addr][3];
   assign oBusy       = busy_q;
   assign oKey_ready  = ready_q;
   assign oParam_load = param_q;
   assign oRound      = round_q;
   assign oSize       = size_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key expansion vectors.
module tb_aes_key_expand;

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic        iKey_load = 1'b0;
   logic [3:0]  iKey_size = 4'd4;
   logic [31:0] iKey_1 = '0, iKey_2 = '0, iKey_3 = '0, iKey_4 = '0;
   logic [31:0] iKey_5 = '0, iKey_6 = '0, iKey_7 = '0, iKey_8 = '0;
   logic [3:0]  iRAM_addr = '0;
   logic [31:0] oRAM_data_1, oRAM_data_2, oRAM_data_3, oRAM_data_4;
   logic        oBusy, oKey_ready, oParam_load;
   logic [3:0]  oRound, oSize;
`ifdef AES_KEY_ZEROIZE_EN
   logic        iZeroize = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   aes_key_expand dut (
      .iClk        (iClk),
      .iRst        (iRst),
`ifdef AES_KEY_ZEROIZE_EN
      .iZeroize    (iZeroize),
`endif
      .iKey_load   (iKey_load),
      .iKey_size   (iKey_size),
      .iKey_1      (iKey_1),
      .iKey_2      (iKey_2),
      .iKey_3      (iKey_3),
      .iKey_4      (iKey_4),
      .iKey_5      (iKey_5),
      .iKey_6      (iKey_6),
      .iKey_7      (iKey_7),
      .iKey_8      (iKey_8),
      .iRAM_addr   (iRAM_addr),
      .oRAM_data_1 (oRAM_data_1),
      .oRAM_data_2 (oRAM_data_2),
      .oRAM_data_3 (oRAM_data_3),
      .oRAM_data_4 (oRAM_data_4),
      .oBusy       (oBusy),
      .oKey_ready  (oKey_ready),
      .oParam_load (oParam_load),
      .oRound      (oRound),
      .oSize       (oSize)
   );

   always #5 iClk = ~iClk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_key(input logic [3:0] sz, input logic [255:0] key);
      @(negedge iClk);
      iKey_size = sz;
      {iKey_1, iKey_2, iKey_3, iKey_4, iKey_5, iKey_6, iKey_7, iKey_8} = key;
      iKey_load = 1'b1;
      @(posedge iClk);
      #1 iKey_load = 1'b0;
   endtask

   // Counts edges after the load edge until oKey_ready; gives up after 100.
   task automatic wait_ready(output int edges, output logic pl);
      edges = 0;
      while (edges < 100 && !oKey_ready) begin
         @(posedge iClk);
         #1 edges++;
      end
      pl = oParam_load;
   endtask

   task automatic read_entry(input string tag, input logic [3:0] addr, input logic [127:0] exp);
      iRAM_addr = addr;
      #1;
      check_eq($sformatf("%s_w0", tag), oRAM_data_1, exp[127:96]);
      check_eq($sformatf("%s_w1", tag), oRAM_data_2, exp[95:64]);
      check_eq($sformatf("%s_w2", tag), oRAM_data_3, exp[63:32]);
      check_eq($sformatf("%s_w3", tag), oRAM_data_4, exp[31:0]);
   endtask

   task automatic finish_run(input string tag, input int exp_edges, input logic [3:0] exp_nr,
                             input logic [3:0] exp_nk);
      int   edges;
      logic pl;
      wait_ready(edges, pl);
      check_eq($sformatf("%s_latency", tag), 32'(edges), 32'(exp_edges));
      check_eq($sformatf("%s_param_rise", tag), 32'(pl), 32'd1);
      check_eq($sformatf("%s_busy_done", tag), 32'(oBusy), 32'd0);
      check_eq($sformatf("%s_round", tag), 32'(oRound), 32'(exp_nr));
      check_eq($sformatf("%s_size", tag), 32'(oSize), 32'(exp_nk));
      @(posedge iClk);
      #1;
      check_eq($sformatf("%s_param_fall", tag), 32'(oParam_load), 32'd0);
      check_eq($sformatf("%s_ready_hold", tag), 32'(oKey_ready), 32'd1);
   endtask

   initial begin
      repeat (2) @(posedge iClk);
      #1;
      check_eq("rst_busy", 32'(oBusy), 32'd0);
      check_eq("rst_ready", 32'(oKey_ready), 32'd0);
      check_eq("rst_param", 32'(oParam_load), 32'd0);
      check_eq("rst_round", 32'(oRound), 32'd0);
      check_eq("rst_size", 32'(oSize), 32'd0);
      @(negedge iClk);
      iRst = 1'b0;

      load_key(4'd4, KEY128);
      check_eq("a128_busy_start", 32'(oBusy), 32'd1);
      finish_run("a128", 40, 4'd10, 4'd4);
      read_entry("a128_r10", 4'd10, R128_10);
      read_entry("a128_r1", 4'd1, R128_1);
      read_entry("a128_r0", 4'd0, KEY128[255:128]);

      load_key(4'd6, KEY192);
      check_eq("a192_ready_drop", 32'(oKey_ready), 32'd0);
      finish_run("a192", 46, 4'd12, 4'd6);
      read_entry("a192_r12", 4'd12, R192_12);

      load_key(4'd8, KEY256);
      finish_run("a256", 52, 4'd14, 4'd8);
      read_entry("a256_r14", 4'd14, R256_14);

      // Abort a 256-bit expansion with a 128-bit reload on edge 20.
      load_key(4'd8, KEY256);
      repeat (18) @(posedge iClk);
      #1;
      check_eq("abort_busy_mid", 32'(oBusy), 32'd1);
      check_eq("abort_ready_mid", 32'(oKey_ready), 32'd0);
      load_key(4'd4, KEY128);
      finish_run("abort", 40, 4'd10, 4'd4);
      read_entry("abort_r10", 4'd10, R128_10);

      load_key(4'd5, KEY128);
      finish_run("size5", 40, 4'd10, 4'd4);
      read_entry("size5_r10", 4'd10, R128_10);

      load_key(4'd4, KEY128);
      repeat (10) @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b1;
      @(posedge iClk);
      #1;
      check_eq("midrst_busy", 32'(oBusy), 32'd0);
      check_eq("midrst_ready", 32'(oKey_ready), 32'd0);
      check_eq("midrst_round", 32'(oRound), 32'd0);
      @(negedge iClk);
      iRst = 1'b0;

`ifdef AES_KEY_ZEROIZE_EN
      load_key(4'd4, KEY128);
      finish_run("zer", 40, 4'd10, 4'd4);
      @(negedge iClk);
      iZeroize = 1'b1;
      @(posedge iClk);
      #1 iZeroize = 1'b0;
      check_eq("zer_ready", 32'(oKey_ready), 32'd0);
      for (int a = 0; a < 16; a++) begin
         read_entry($sformatf("zer_r%0d", a), 4'(a), 128'h0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
